// File: rtl/serial_frame_feeder.sv
// ============================================================================
// Module  : serial_frame_feeder
// Brief   : Skid-buffered beat serialiser that feeds a serial divisibility
//           checker MSB-first and frames each value with its active-low clear.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module serial_frame_feeder #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_last,
    output logic             ser_din,
    output logic             ser_resetn,
    output logic             ser_last,
    output logic             busy,
    output logic             underrun
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_SHIFT   = 2'd1;
    localparam logic [1:0]       c_DRAIN   = 2'd2;
    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    logic [1:0]       r_state;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_buf_data;
    logic [LEN_W-1:0] r_buf_len;
    logic             r_buf_last;
    logic [WIDTH-1:0] r_sh_data;
    logic [LEN_W-1:0] r_sh_cnt;
    logic             r_sh_last;
    logic             r_ser_din;
    logic             r_ser_resetn;
    logic             r_ser_last;
    logic             r_underrun;

    logic [LEN_W-1:0] w_in_len;
    logic             w_beat_end;
    logic             w_load;
    logic             w_underrun;
    logic             w_accept;
    logic             w_discard;
    logic [WIDTH-1:0] w_aligned;

    assign w_in_len   = ((in_len == '0) || (in_len > c_LEN_MAX)) ? c_LEN_MAX : in_len;
    // r_sh_cnt counts bits still to come after the one currently on ser_din
    assign w_beat_end = (r_state == c_SHIFT) && (r_sh_cnt == '0);
    assign w_load     = r_buf_full && ((r_state == c_IDLE) || (w_beat_end && !r_sh_last));
    assign w_underrun = w_beat_end && !r_sh_last && !r_buf_full;
    assign in_ready   = !r_buf_full || w_load;
    assign w_accept   = in_valid && in_ready;
    // Beats arriving once a frame has been aborted belong to that frame
    assign w_discard  = (r_state == c_DRAIN) || w_underrun;
    // Left-justify the significant bits; anything above in_len-1 falls off the top
    assign w_aligned  = r_buf_data << (c_LEN_MAX - r_buf_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_buf_full   <= 1'b0;
            r_buf_data   <= '0;
            r_buf_len    <= '0;
            r_buf_last   <= 1'b0;
            r_sh_data    <= '0;
            r_sh_cnt     <= '0;
            r_sh_last    <= 1'b0;
            r_ser_din    <= 1'b0;
            r_ser_resetn <= 1'b0;
            r_ser_last   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_accept && !w_discard) begin
                r_buf_full <= 1'b1;
                r_buf_data <= in_data;
                r_buf_len  <= w_in_len;
                r_buf_last <= in_last;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            if (w_load) begin
                r_state      <= c_SHIFT;
                r_ser_resetn <= 1'b1;
                r_ser_din    <= w_aligned[WIDTH-1];
                r_sh_data    <= w_aligned << 1;
                r_sh_cnt     <= r_buf_len - c_ONE;
                r_sh_last    <= r_buf_last;
                r_ser_last   <= r_buf_last && (r_buf_len == c_ONE);
            end else begin
                case (r_state)
                    c_SHIFT: begin
                        if (!w_beat_end) begin
                            r_ser_din  <= r_sh_data[WIDTH-1];
                            r_sh_data  <= r_sh_data << 1;
                            r_sh_cnt   <= r_sh_cnt - c_ONE;
                            r_ser_last <= r_sh_last && (r_sh_cnt == c_ONE);
                        end else begin
                            r_ser_resetn <= 1'b0;
                            r_ser_din    <= 1'b0;
                            r_ser_last   <= 1'b0;
                            if (r_sh_last) begin
                                r_state <= c_IDLE;
                            end else begin
                                r_underrun <= 1'b1;
                                r_state    <= (w_accept && in_last) ? c_IDLE : c_DRAIN;
                            end
                        end
                    end
                    c_DRAIN: begin
                        if (w_accept && in_last) begin
                            r_state <= c_IDLE;
                        end
                    end
                    c_IDLE: begin
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign ser_din    = r_ser_din;
    assign ser_resetn = r_ser_resetn;
    assign ser_last   = r_ser_last;
    assign underrun   = r_underrun;
    assign busy       = (r_state != c_IDLE) || r_buf_full;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_feeder.sv
// ============================================================================
// Module  : tb_serial_frame_feeder
// Brief   : Self-checking bench for serial_frame_feeder with a mod-3 checker
//           model and a frame scoreboard.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_feeder;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic [LEN_W-1:0] in_len   = '0;
    logic             in_last  = 1'b0;
    logic             in_ready;
    logic             ser_din;
    logic             ser_resetn;
    logic             ser_last;
    logic             busy;
    logic             underrun;

    always #5 clk = ~clk;

    serial_frame_feeder #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_last    (in_last),
        .ser_din    (ser_din),
        .ser_resetn (ser_resetn),
        .ser_last   (ser_last),
        .busy       (busy),
        .underrun   (underrun)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic       last;
        int         gap;
        int         exp_val;
        int         exp_bits;
        logic       exp_dout;
    } vec_t;

    typedef struct {
        int   val;
        int   bits;
        logic dout;
    } frame_t;

    frame_t sb[$];
    vec_t   vt[9];
    int     n_checks   = 0;
    int     n_fail     = 0;
    int     abort_cnt  = 0;
    int     abort_bits = 0;
    int     rem        = 0;
    int     acc        = 0;
    int     nbits      = 0;
    bit     dout_pend  = 1'b0;
    logic   exp_dout_q = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Downstream divisibility-by-3 checker model
    always @(posedge clk) begin
        if (ser_resetn !== 1'b1) rem <= 0;
        else                     rem <= (2 * rem + int'(ser_din)) % 3;
    end

    always @(negedge clk) begin
        if (dout_pend) begin
            check("dout", int'(rem == 0), int'(exp_dout_q));
            check("gap_after_last", int'(ser_resetn === 1'b1), 0);
            dout_pend = 1'b0;
        end
        if (ser_resetn === 1'b1) begin
            acc = (acc << 1) | int'(ser_din === 1'b1);
            nbits++;
            if (ser_last === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got value %0d bits %0d, expected no frame", acc, nbits);
                end else begin
                    frame_t f;
                    f = sb.pop_front();
                    check("frame_val", acc, f.val);
                    check("frame_bits", nbits, f.bits);
                    exp_dout_q = f.dout;
                    dout_pend  = 1'b1;
                end
                acc   = 0;
                nbits = 0;
            end
        end else begin
            if (nbits != 0) begin
                abort_cnt++;
                abort_bits = nbits;
                nbits = 0;
                acc   = 0;
            end
            if ((ser_last === 1'b1) || (ser_din === 1'b1)) begin
                check("cleared_outputs", int'({ser_din, ser_last}), 0);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [3:0] l, input logic lst);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        in_last  = lst;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles, expected 1", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || ser_resetn || sb.size() != 0 || dout_pend) && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (t >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d frames outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int a0;
        vt[0] = '{8'h06, 4'd3, 1'b1, 0, 6,   3, 1'b1};
        vt[1] = '{8'h0A, 4'd4, 1'b0, 0, 0,   0, 1'b0};
        vt[2] = '{8'h01, 4'd2, 1'b1, 0, 41,  6, 1'b0};
        vt[3] = '{8'h03, 4'd0, 1'b1, 2, 3,   8, 1'b1};
        vt[4] = '{8'hA5, 4'd9, 1'b1, 0, 165, 8, 1'b1};
        vt[5] = '{8'hF5, 4'd3, 1'b1, 3, 5,   3, 1'b0};
        vt[6] = '{8'h02, 4'd2, 1'b0, 0, 0,   0, 1'b0};
        vt[7] = '{8'h07, 4'd3, 1'b0, 0, 0,   0, 1'b0};
        vt[8] = '{8'h00, 4'd1, 1'b1, 0, 46,  6, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_resetn",   int'(ser_resetn), 0);
        check("rst_din",      int'(ser_din), 0);
        check("rst_last",     int'(ser_last), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_busy",     int'(busy), 0);
        check("rst_ready",    int'(in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // Single beat: first bit two cycles after acceptance
        sb.push_back('{6, 3, 1'b1});
        in_valid = 1'b1; in_data = 8'h06; in_len = 4'd3; in_last = 1'b1;
        check("lat_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_k1_resetn", int'(ser_resetn), 0);
        @(negedge clk);
        check("lat_k2_resetn", int'(ser_resetn), 1);
        check("lat_k2_din",    int'(ser_din), 1);
        wait_idle();

        for (int i = 0; i < 9; i++) begin
            idle(vt[i].gap);
            if (vt[i].last) sb.push_back('{vt[i].exp_val, vt[i].exp_bits, vt[i].exp_dout});
            send_beat(vt[i].data, vt[i].len, vt[i].last);
        end
        wait_idle();

        // Four single-bit beats streamed with in_valid held high
        sb.push_back('{9, 4, 1'b1});
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0 || i == 3) ? 8'h01 : 8'h00;
            in_len   = 4'd1;
            in_last  = (i == 3);
            check("stream_ready", int'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();

        // Underrun: frame starved mid-way, tail beat dropped, next frame clean
        a0 = abort_cnt;
        send_beat(8'h03, 4'd2, 1'b0);
        idle(5);
        send_beat(8'h00, 4'd1, 1'b1);
        sb.push_back('{3, 2, 1'b1});
        send_beat(8'h03, 4'd2, 1'b1);
        wait_idle();
        check("underrun_flag",  int'(underrun), 1);
        check("underrun_abort", abort_cnt - a0, 1);
        check("underrun_bits",  abort_bits, 2);

        // Reset in the middle of an 8-bit frame
        send_beat(8'hFF, 4'd8, 1'b1);
        repeat (3) @(negedge clk);
        check("midframe_active", int'(ser_resetn), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_resetn",   int'(ser_resetn), 0);
        check("mid_rst_din",      int'(ser_din), 0);
        check("mid_rst_last",     int'(ser_last), 0);
        check("mid_rst_ready",    int'(in_ready), 1);
        check("mid_rst_busy",     int'(busy), 0);
        check("mid_rst_underrun", int'(underrun), 0);
        sb.push_back('{3, 2, 1'b1});
        send_beat(8'h03, 4'd2, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
